multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle instruction decoder.
- Sequences a shared-ALU, shared-memory MIPS datapath through FETCH, DECODE, EXE, MEM and WB states.
- Asserts per-state enables for PC, IR, register file and data memory, and waits on memory-ready handshakes.
- Supported ISA: addu, subu, addi, ori, lui, lw, sw, beq, j, jal, jr, jalr, nop. Any other encoding executes as nop.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low. 0 resets immediately; release is sampled on clk.
- instr  in  32  IR contents; valid from DECODE onward.
- zero  in  1  ALU equality flag, sampled in EXE for beq.
- im_ready  in  1  instruction memory data valid.
- dm_ready  in  1  data memory access complete.
- PCWr  out  1  PC write enable.
- NPCop  out  2  next-PC select: 00 PC+4, 01 branch target, 10 j/jal target, 11 GPR[rs].
- IRWr  out  1  IR write enable.
- ALUop  out  3  000 add, 001 sub, 010 or, 100 lui.
- ALUmux  out  1  1 selects extended immediate as ALU B.
- EXTop  out  1  1 sign-extend, 0 zero-extend.
- A3mux  out  2  00 rd, 01 rt, 10 $31.
- REGmux  out  2  00 ALU result, 01 DM data, 10 PC (already PC+4).
- RegWrite  out  1  register-file write enable.
- MemRead  out  1  data memory read strobe.
- MemWrite  out  1  data memory write strobe.
- state  out  3  FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- instr_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, while reset=0): state=FETCH, instr_cnt=0, registered outputs 0. All strobes are low while reset=0.
- Outputs are combinational from state and decoded instr. Unlisted outputs are 0 in every state.
- Decode fields: op=instr[31:26], funct=instr[5:0]. R-type is op=0 with funct 100001 (addu), 100011 (subu), 001000 (jr), 001001 (jalr).
- nop is instr==32'h0. An op=0 word with an unknown funct is also treated as nop.

State behaviour:
- FETCH: IRWr=1, PCWr=1, NPCop=00 only when im_ready=1. Stay while im_ready=0, with PCWr and IRWr held low. On im_ready=1, go to DECODE.
- DECODE for j: PCWr=1, NPCop=10, retire=1, then FETCH.
- DECODE for jr: PCWr=1, NPCop=11, retire=1, then FETCH.
- DECODE for nop/unknown: retire=1, then FETCH.
- DECODE for jal/jalr: go to WB.
- DECODE for all other instructions: go to EXE.
- EXE: drives ALUop, ALUmux and EXTop per the decode table below.
  - beq: ALUop=001; PCWr=zero, NPCop=01; retire=1; then FETCH.
  - lw/sw: ALUop=000, ALUmux=1, EXTop=1; then MEM.
  - Other instructions: then WB.
- MEM: MemRead=lw, MemWrite=sw, held until dm_ready=1. On dm_ready, lw goes to WB; sw sets retire=1 and goes to FETCH. The strobe stays continuously high while waiting; the memory must not double-write.
- WB: RegWrite=1 for exactly one cycle, retire=1, then FETCH.
  - addu/subu: A3mux=00, REGmux=00.
  - ori/lui/addi: A3mux=01, REGmux=00.
  - lw: A3mux=01, REGmux=01.
  - jal: A3mux=10, REGmux=10, plus PCWr=1, NPCop=10.
  - jalr: A3mux=00 (rd), REGmux=10, plus PCWr=1, NPCop=11.
  - The link register and PC share the same edge, so the link value is the old PC (PC+4).

Decode table:
- ALUop: subu 001, ori 010, lui 100, else 000.
- ALUmux=1 for ori, lui, addi, lw, sw.
- EXTop=1 for addi, lw, sw, beq.

Cycle counts:
- j, jr, nop: 2.
- beq, jal, jalr: 3.
- R-type ALU, immediates, sw: 4.
- lw: 5.
- Each count is extended by memory wait cycles.

Counter and fault handling:
- instr_cnt increments on each retire edge and wraps from all-ones to 0.
- Reset asserted mid-instruction aborts immediately; no strobe completes afterwards.
- Unknown state encodings (5-7) return to FETCH on the next edge.

Test Plan:
- Reset held low 3 cycles, then released with im_ready=1 -> state=0, IRWr=1, PCWr=1 in first cycle; instr_cnt=0.
- addu $3,$1,$2 (0x00221821) -> states 0,1,2,4. In WB: RegWrite=1, A3mux=00, REGmux=00. retire pulses once; instr_cnt=1.
- lw $2,4($1) (0x8C220004) with dm_ready low 3 cycles -> MemRead high 4 consecutive cycles, WB with REGmux=01, A3mux=01; total 8 cycles.
- beq (0x10220003) with zero=1, then zero=0 -> first: PCWr=1, NPCop=01 in EXE. Second: PCWr=0. Each takes 3 cycles.
- jal (0x0C000010) then jr $31 (0x03E00008) -> jal WB: RegWrite=1, A3mux=10, REGmux=10, PCWr=1, NPCop=10. jr: PCWr=1, NPCop=11 in DECODE, no RegWrite.
- im_ready low 2 cycles in FETCH, then reset pulse during MEM of sw (0xAC220000) -> no PCWr/IRWr while waiting. MemWrite drops asynchronously, state=0, instr_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for a shared-ALU, shared-memory MIPS datapath.
// Walks FETCH/DECODE/EXE/MEM/WB per instruction and counts retired instructions.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             zero,
   input  logic             im_ready,
   input  logic             dm_ready,
   output logic             PCWr,
   output logic [1:0]       NPCop,
   output logic             IRWr,
   output logic [2:0]       ALUop,
   output logic             ALUmux,
   output logic             EXTop,
   output logic [1:0]       A3mux,
   output logic [1:0]       REGmux,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [2:0]       state,
   output logic             retire,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [5:0] op, funct;
   logic       is_r, is_addu, is_subu, is_jr, is_jalr;
   logic       is_addi, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
   logic       goes_exe;
   logic       unused_instr_bits;

   assign op    = instr[31:26];
   assign funct = instr[5:0];
   assign unused_instr_bits = ^instr[25:6];

   assign is_r    = (op == 6'b000000);
   assign is_addu = is_r && (funct == 6'b100001);
   assign is_subu = is_r && (funct == 6'b100011);
   assign is_jr   = is_r && (funct == 6'b001000);
   assign is_jalr = is_r && (funct == 6'b001001);
   assign is_addi = (op == 6'b001000);
   assign is_ori  = (op == 6'b001101);
   assign is_lui  = (op == 6'b001111);
   assign is_lw   = (op == 6'b100011);
   assign is_sw   = (op == 6'b101011);
   assign is_beq  = (op == 6'b000100);
   assign is_j    = (op == 6'b000010);
   assign is_jal  = (op == 6'b000011);

   // Everything not listed here (and not a jump) retires as a nop in DECODE.
   assign goes_exe = is_addu | is_subu | is_addi | is_ori | is_lui |
                     is_lw | is_sw | is_beq;

   always_comb begin
      state_d  = state_q;
      PCWr     = 1'b0;
      NPCop    = 2'b00;
      IRWr     = 1'b0;
      ALUop    = 3'b000;
      ALUmux   = 1'b0;
      EXTop    = 1'b0;
      A3mux    = 2'b00;
      REGmux   = 2'b00;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      retire   = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (im_ready) begin
               IRWr    = 1'b1;
               PCWr    = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_j || is_jr) begin
               PCWr    = 1'b1;
               NPCop   = is_j ? 2'b10 : 2'b11;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (is_jal || is_jalr) begin
               state_d = S_WB;
            end else if (goes_exe) begin
               state_d = S_EXE;
            end else begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXE: begin
            if (is_subu || is_beq) ALUop = 3'b001;
            else if (is_ori)       ALUop = 3'b010;
            else if (is_lui)       ALUop = 3'b100;
            ALUmux = is_ori | is_lui | is_addi | is_lw | is_sw;
            EXTop  = is_addi | is_lw | is_sw | is_beq;
            if (is_beq) begin
               PCWr    = zero;
               NPCop   = 2'b01;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            // Strobe stays asserted through the ready cycle so each access is one request.
            MemRead  = is_lw;
            MemWrite = is_sw;
            if (!(is_lw || is_sw)) begin
               state_d = S_FETCH;
            end else if (dm_ready) begin
               retire  = is_sw;
               state_d = is_lw ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
            if (is_jal || is_jalr) begin
               A3mux  = is_jal ? 2'b10 : 2'b00;
               REGmux = 2'b10;
               PCWr   = 1'b1;
               NPCop  = is_jal ? 2'b10 : 2'b11;
            end else if (is_lw) begin
               A3mux  = 2'b01;
               REGmux = 2'b01;
            end else if (is_ori || is_lui || is_addi) begin
               A3mux  = 2'b01;
            end
         end
         default: state_d = S_FETCH;
      endcase

      // Strobes are suppressed combinationally so an asserted reset kills them at once.
      if (!reset) begin
         PCWr     = 1'b0;
         NPCop    = 2'b00;
         IRWr     = 1'b0;
         ALUop    = 3'b000;
         ALUmux   = 1'b0;
         EXTop    = 1'b0;
         A3mux    = 2'b00;
         REGmux   = 2'b00;
         RegWrite = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         retire   = 1'b0;
      end

      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state     = state_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle outputs, compared on every falling edge.
module tb_multicycle_ctrl;

   localparam int CW = 4;

   localparam int K_NOP  = 0;
   localparam int K_ADDU = 1;
   localparam int K_SUBU = 2;
   localparam int K_JR   = 3;
   localparam int K_JALR = 4;
   localparam int K_ADDI = 5;
   localparam int K_ORI  = 6;
   localparam int K_LUI  = 7;
   localparam int K_LW   = 8;
   localparam int K_SW   = 9;
   localparam int K_BEQ  = 10;
   localparam int K_J    = 11;
   localparam int K_JAL  = 12;

   logic          clk, reset, zero, im_ready, dm_ready;
   logic [31:0]   instr;
   logic          PCWr, IRWr, ALUmux, EXTop, RegWrite, MemRead, MemWrite, retire;
   logic [1:0]    NPCop, A3mux, REGmux;
   logic [2:0]    ALUop, state;
   logic [CW-1:0] instr_cnt;

   multicycle_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero),
      .im_ready(im_ready), .dm_ready(dm_ready),
      .PCWr(PCWr), .NPCop(NPCop), .IRWr(IRWr), .ALUop(ALUop),
      .ALUmux(ALUmux), .EXTop(EXTop), .A3mux(A3mux), .REGmux(REGmux),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .state(state), .retire(retire), .instr_cnt(instr_cnt)
   );

   typedef struct packed {
      logic          rst_n, im_rdy, dm_rdy, zero_v;
      logic [31:0]   ins;
      logic [2:0]    st;
      logic          pcwr;
      logic [1:0]    npc;
      logic          irwr;
      logic [2:0]    aluop;
      logic          alumux, ext;
      logic [1:0]    a3, regmux;
      logic          regw, mrd, mwr, ret;
      logic [CW-1:0] cnt;
   } cyc_t;

   cyc_t          exp_q[$];
   int            ret_len[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc_n = 0;
   int            run_len = 0;
   int            mrd_cur = 0;
   int            mrd_last = 0;
   logic [CW-1:0] mcnt = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   // Compare process plus retire-length / MemRead-run monitors.
   always @(negedge clk) begin
      cyc_t e;
      logic [20+CW-1:0] act, req;
      cyc_n++;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = {state, PCWr, NPCop, IRWr, ALUop, ALUmux, EXTop, A3mux, REGmux,
                RegWrite, MemRead, MemWrite, retire, instr_cnt};
         req = {e.st, e.pcwr, e.npc, e.irwr, e.aluop, e.alumux, e.ext, e.a3, e.regmux,
                e.regw, e.mrd, e.mwr, e.ret, e.cnt};
         checks++;
         if (act !== req) begin
            errors++;
            $display("FAIL outputs cycle %0d instr=%08h: got %h required %h (st,pcwr,npc,irwr,alu,amux,ext,a3,rmux,rw,mr,mw,ret,cnt)",
                     cyc_n, e.ins, act, req);
         end
      end
      if (!reset) begin
         run_len = 0;
         mrd_cur = 0;
      end else begin
         run_len++;
         if (retire) begin
            ret_len.push_back(run_len);
            run_len = 0;
         end
         if (MemRead) mrd_cur++;
         else if (mrd_cur != 0) begin
            mrd_last = mrd_cur;
            mrd_cur  = 0;
         end
      end
   end

   function automatic int kind(input logic [31:0] w);
      logic [5:0] op, fn;
      op = w[31:26];
      fn = w[5:0];
      case (op)
         6'h00: case (fn)
                   6'h21:   return K_ADDU;
                   6'h23:   return K_SUBU;
                   6'h08:   return K_JR;
                   6'h09:   return K_JALR;
                   default: return K_NOP;
                endcase
         6'h08:   return K_ADDI;
         6'h0D:   return K_ORI;
         6'h0F:   return K_LUI;
         6'h23:   return K_LW;
         6'h2B:   return K_SW;
         6'h04:   return K_BEQ;
         6'h02:   return K_J;
         6'h03:   return K_JAL;
         default: return K_NOP;
      endcase
   endfunction

   function automatic cyc_t blank(input logic [31:0] ins, input logic [2:0] st);
      cyc_t e;
      e        = '0;
      e.rst_n  = 1'b1;
      e.im_rdy = 1'b1;
      e.dm_rdy = 1'b1;
      e.ins    = ins;
      e.st     = st;
      return e;
   endfunction

   task automatic cyc(input cyc_t e);
      @(posedge clk);
      #1;
      reset    = e.rst_n;
      im_ready = e.im_rdy;
      dm_ready = e.dm_rdy;
      zero     = e.zero_v;
      instr    = e.ins;
      if (!e.rst_n) mcnt = '0;
      e.cnt = mcnt;
      if (e.ret) mcnt = mcnt + CW'(1);
      exp_q.push_back(e);
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_len(input string nm, input int req);
      int got;
      settle();
      if (ret_len.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got no retire, required length %0d", nm, req);
      end else begin
         got = ret_len.pop_front();
         lit(nm, 32'(got), 32'(req));
      end
   endtask

   // One FETCH cycle with im_ready low, so the counter can be read after its update.
   task automatic cnt_check(input string nm, input int req);
      cyc_t e;
      e = blank(32'h0, 3'd0);
      e.im_rdy = 1'b0;
      cyc(e);
      settle();
      lit(nm, 32'(instr_cnt), 32'(req));
   endtask

   task automatic run_instr(input logic [31:0] ins, input int im_wait,
                            input int dm_wait, input logic z);
      cyc_t e;
      int   k;
      k = kind(ins);
      for (int i = 0; i < im_wait; i++) begin
         e = blank(ins, 3'd0);
         e.im_rdy = 1'b0;
         cyc(e);
      end
      e = blank(ins, 3'd0);
      e.irwr = 1'b1;
      e.pcwr = 1'b1;
      cyc(e);
      e = blank(ins, 3'd1);
      case (k)
         K_J, K_JR: begin
            e.pcwr = 1'b1;
            e.npc  = (k == K_J) ? 2'b10 : 2'b11;
            e.ret  = 1'b1;
            cyc(e);
         end
         K_NOP: begin
            e.ret = 1'b1;
            cyc(e);
         end
         K_JAL, K_JALR: begin
            cyc(e);
            e = blank(ins, 3'd4);
            e.regw   = 1'b1;
            e.ret    = 1'b1;
            e.regmux = 2'b10;
            e.pcwr   = 1'b1;
            e.a3     = (k == K_JAL) ? 2'b10 : 2'b00;
            e.npc    = (k == K_JAL) ? 2'b10 : 2'b11;
            cyc(e);
         end
         default: begin
            cyc(e);
            e = blank(ins, 3'd2);
            e.aluop  = (k == K_SUBU || k == K_BEQ) ? 3'b001 :
                       (k == K_ORI) ? 3'b010 : (k == K_LUI) ? 3'b100 : 3'b000;
            e.alumux = (k inside {K_ORI, K_LUI, K_ADDI, K_LW, K_SW});
            e.ext    = (k inside {K_ADDI, K_LW, K_SW, K_BEQ});
            if (k == K_BEQ) begin
               e.zero_v = z;
               e.pcwr   = z;
               e.npc    = 2'b01;
               e.ret    = 1'b1;
               cyc(e);
            end else begin
               cyc(e);
               if (k == K_LW || k == K_SW) begin
                  for (int i = 0; i <= dm_wait; i++) begin
                     e = blank(ins, 3'd3);
                     e.dm_rdy = (i == dm_wait);
                     e.mrd    = (k == K_LW);
                     e.mwr    = (k == K_SW);
                     e.ret    = (k == K_SW) && (i == dm_wait);
                     cyc(e);
                  end
               end
               if (k != K_SW) begin
                  e = blank(ins, 3'd4);
                  e.regw   = 1'b1;
                  e.ret    = 1'b1;
                  e.a3     = (k inside {K_LW, K_ORI, K_LUI, K_ADDI}) ? 2'b01 : 2'b00;
                  e.regmux = (k == K_LW) ? 2'b01 : 2'b00;
                  cyc(e);
               end
            end
         end
      endcase
   endtask

   initial begin
      cyc_t e;
      reset    = 1'b0;
      im_ready = 1'b1;
      dm_ready = 1'b0;
      zero     = 1'b0;
      instr    = 32'h0;

      // Reset held for three cycles with im_ready high: everything must stay quiet.
      for (int i = 0; i < 3; i++) begin
         e = blank(32'h0, 3'd0);
         e.rst_n = 1'b0;
         cyc(e);
      end

      run_instr(32'h00221821, 0, 0, 1'b0);  chk_len("addu cycles", 4);
      cnt_check("instr_cnt after addu", 1);
      run_instr(32'h8C220004, 0, 3, 1'b0);  chk_len("lw cycles incl idle", 8 + 1);
      lit("lw MemRead run", 32'(mrd_last), 32'd4);
      run_instr(32'h10220003, 0, 0, 1'b1);  chk_len("beq taken cycles", 3);
      run_instr(32'h10220003, 0, 0, 1'b0);  chk_len("beq not-taken cycles", 3);
      run_instr(32'h0C000010, 0, 0, 1'b0);  chk_len("jal cycles", 3);
      run_instr(32'h03E00008, 0, 0, 1'b0);  chk_len("jr cycles", 2);
      cnt_check("instr_cnt after jr", 6);
      run_instr(32'h08000010, 0, 0, 1'b0);  chk_len("j cycles incl idle", 2 + 1);
      run_instr(32'h00000000, 0, 0, 1'b0);  chk_len("nop cycles", 2);
      run_instr(32'hFC000000, 0, 0, 1'b0);  chk_len("unknown op cycles", 2);
      run_instr(32'h0000003F, 0, 0, 1'b0);  chk_len("unknown funct cycles", 2);
      run_instr(32'h342200FF, 0, 0, 1'b0);  chk_len("ori cycles", 4);
      run_instr(32'h00221823, 0, 0, 1'b0);  chk_len("subu cycles", 4);
      run_instr(32'h3C021234, 0, 0, 1'b0);  chk_len("lui cycles", 4);
      run_instr(32'h2022FFFF, 0, 0, 1'b0);  chk_len("addi cycles", 4);
      run_instr(32'h0020F809, 0, 0, 1'b0);  chk_len("jalr cycles", 3);
      cnt_check("instr_cnt after jalr", 15);
      run_instr(32'hAC220000, 0, 1, 1'b0);  chk_len("sw cycles incl idle", 5 + 1);
      cnt_check("instr_cnt wrap", 0);
      run_instr(32'h00000000, 0, 0, 1'b0);  chk_len("nop after wrap incl idle", 2 + 1);
      run_instr(32'h00000000, 0, 0, 1'b0);  chk_len("nop 2 after wrap", 2);
      cnt_check("instr_cnt after wrap", 2);

      // sw with fetch stalls, aborted by reset while MEM waits on dm_ready.
      for (int i = 0; i < 2; i++) begin
         e = blank(32'hAC220000, 3'd0);
         e.im_rdy = 1'b0;
         cyc(e);
      end
      e = blank(32'hAC220000, 3'd0);
      e.irwr = 1'b1;
      e.pcwr = 1'b1;
      cyc(e);
      e = blank(32'hAC220000, 3'd1);
      cyc(e);
      e = blank(32'hAC220000, 3'd2);
      e.alumux = 1'b1;
      e.ext    = 1'b1;
      cyc(e);
      for (int i = 0; i < 2; i++) begin
         e = blank(32'hAC220000, 3'd3);
         e.dm_rdy = 1'b0;
         e.mwr    = 1'b1;
         cyc(e);
      end
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      lit("async MemWrite", 32'(MemWrite), 32'd0);
      lit("async state", 32'(state), 32'd0);
      lit("async instr_cnt", 32'(instr_cnt), 32'd0);
      for (int i = 0; i < 2; i++) begin
         e = blank(32'hAC220000, 3'd0);
         e.rst_n  = 1'b0;
         e.dm_rdy = 1'b1;
         cyc(e);
      end
      run_instr(32'h00221821, 0, 0, 1'b0);  chk_len("addu after abort", 4);
      cnt_check("instr_cnt after abort", 1);

      settle();
      lit("expectations drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
